// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser plus per-channel debounce FSM, giving a level and press/release strobes.
// Optional auto-repeat strobes are enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int RPT_W           = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               btn_any
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMING    = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] DISARMING = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject configurations where a counter could wrap before reaching its terminal value.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (2 ** CNT_W)) begin : gBadDebounce
        $error("button_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        HOLD_CYCLES > (2 ** RPT_W) || REPEAT_CYCLES > (2 ** RPT_W)) begin : gBadRepeat
        $error("button_conditioner: HOLD_CYCLES/REPEAT_CYCLES do not fit RPT_W");
    end

    logic [NUM_BTN-1:0] syncMeta;
    logic [NUM_BTN-1:0] syncOut;
    logic [NUM_BTN-1:0] pressNxt;
    logic [NUM_BTN-1:0] releaseNxt;
    logic [NUM_BTN-1:0] levelNxt;
    logic [NUM_BTN-1:0] repeatNxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta <= '0;
            syncOut  <= '0;
        end else begin
            syncMeta <= btn_raw;
            syncOut  <= syncMeta;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
        logic [1:0]       state;
        logic [1:0]       stateNxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cntNxt;
        logic             pressC;
        logic             releaseC;

        always_comb begin
            stateNxt = state;
            cntNxt   = cnt;
            pressC   = 1'b0;
            releaseC = 1'b0;
            case (state)
                IDLE: begin
                    if (syncOut[i]) begin
                        stateNxt = ARMING;
                        cntNxt   = '0;
                    end
                end
                ARMING: begin
                    if (!syncOut[i]) begin
                        stateNxt = IDLE;
                        cntNxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        stateNxt = HELD;
                        cntNxt   = '0;
                        pressC   = 1'b1;
                    end else begin
                        cntNxt = cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!syncOut[i]) begin
                        stateNxt = DISARMING;
                        cntNxt   = '0;
                    end
                end
                default: begin
                    if (syncOut[i]) begin
                        stateNxt = HELD;
                        cntNxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        stateNxt = IDLE;
                        cntNxt   = '0;
                        releaseC = 1'b1;
                    end else begin
                        cntNxt = cnt + CNT_ONE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= stateNxt;
                cnt   <= cntNxt;
            end
        end

        assign pressNxt[i]   = pressC;
        assign releaseNxt[i] = releaseC;
        assign levelNxt[i]   = (stateNxt == HELD) || (stateNxt == DISARMING);

`ifdef BUTTON_AUTOREPEAT_EN
        localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
        localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_CYCLES - 1);
        localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

        logic [RPT_W-1:0] rptCnt;
        logic             rptFirst;
        logic             rptC;

        // Counter only advances while the state register shows HELD, so DISARMING pauses it.
        assign rptC = (state == HELD) && (rptCnt == (rptFirst ? HOLD_LAST : REP_LAST));

        always_ff @(posedge clk) begin
            if (rst || stateNxt == IDLE || pressC) begin
                rptCnt   <= '0;
                rptFirst <= 1'b1;
            end else if (rptC) begin
                rptCnt   <= '0;
                rptFirst <= 1'b0;
            end else if (state == HELD) begin
                rptCnt <= rptCnt + RPT_ONE;
            end
        end

        assign repeatNxt[i] = rptC;
`else
        assign repeatNxt[i] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
            btn_any     <= 1'b0;
        end else begin
            btn_level   <= levelNxt;
            btn_press   <= pressNxt;
            btn_release <= releaseNxt;
            btn_repeat  <= repeatNxt;
            btn_any     <= |pressNxt;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at reduced debounce/repeat lengths.
module tb_button_conditioner;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;
    logic          btn_any;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    int pressCnt   [NB];
    int releaseCnt [NB];
    int repeatCnt  [NB];
    int lastRepeat [NB];
    int anyCnt = 0;
    int anyBad = 0;

    button_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(8), .CNT_W(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .RPT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_any(btn_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled shortly after each edge.
    initial begin
        for (int i = 0; i < NB; i++) begin
            pressCnt[i] = 0; releaseCnt[i] = 0; repeatCnt[i] = 0; lastRepeat[i] = -1;
        end
    end

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i] === 1'b1) pressCnt[i]++;
            if (btn_release[i] === 1'b1) releaseCnt[i]++;
            if (btn_repeat[i] === 1'b1) begin
                repeatCnt[i]++;
                lastRepeat[i] = cyc;
            end
        end
        if (btn_any === 1'b1) anyCnt++;
        if (btn_any !== (|btn_press)) anyBad++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        btn_raw = '0;

        waitCyc(3);
        checkVal("reset_level", 32'(btn_level), 32'h0);
        checkVal("reset_press", 32'(btn_press), 32'h0);
        checkVal("reset_release", 32'(btn_release), 32'h0);
        checkVal("reset_repeat", 32'(btn_repeat), 32'h0);
        checkVal("reset_any", 32'(btn_any), 32'h0);
        rst = 1'b0;

        // Clean press on channel 0, sampled at cycle 10.
        waitCyc(9);  btn_raw[0] = 1'b1;
        waitCyc(19);
        checkVal("press0_early", 32'(btn_press), 32'h0);
        checkVal("level0_early", 32'(btn_level), 32'h0);
        waitCyc(20);
        checkVal("press0", 32'(btn_press), 32'h1);
        checkVal("level0", 32'(btn_level), 32'h1);
        checkVal("any0", 32'(btn_any), 32'h1);
        waitCyc(21);
        checkVal("press0_off", 32'(btn_press), 32'h0);
        checkVal("level0_hold", 32'(btn_level), 32'h1);
        checkVal("any0_off", 32'(btn_any), 32'h0);

        // Release channel 0, sampled at cycle 50.
        waitCyc(49); btn_raw[0] = 1'b0;
        waitCyc(59);
        checkVal("rel0_early", 32'(btn_release), 32'h0);
        checkVal("level0_pre_rel", 32'(btn_level), 32'h1);
        waitCyc(60);
        checkVal("rel0", 32'(btn_release), 32'h1);
        checkVal("level0_rel", 32'(btn_level), 32'h0);
        waitCyc(61);
        checkVal("rel0_off", 32'(btn_release), 32'h0);

        // Bounce on channel 1: 3-cycle toggles for 30 cycles, final rise sampled at cycle 100.
        for (int k = 0; k <= 10; k++) begin
            waitCyc(69 + 3 * k);
            btn_raw[1] = (k % 2 == 0);
        end
        waitCyc(109);
        checkVal("bounce_nopress", 32'(pressCnt[1]), 32'd0);
        checkVal("bounce_level", 32'(btn_level[1]), 32'h0);
        waitCyc(110);
        checkVal("bounce_press", 32'(btn_press), 32'h2);
        checkVal("bounce_norel", 32'(releaseCnt[1]), 32'd0);
        waitCyc(114); btn_raw[1] = 1'b0;
        waitCyc(125);
        checkVal("rel1", 32'(btn_release), 32'h2);

        // Simultaneous press on all channels.
        waitCyc(139); btn_raw = 4'b1111;
        waitCyc(149);
        checkVal("simul_early", 32'(btn_press), 32'h0);
        waitCyc(150);
        checkVal("simul_press", 32'(btn_press), 32'hF);
        checkVal("simul_any", 32'(btn_any), 32'h1);
        waitCyc(151);
        checkVal("simul_press_off", 32'(btn_press), 32'h0);
        checkVal("simul_any_off", 32'(btn_any), 32'h0);

        // One-cycle reset while everything is held.
        waitCyc(159); rst = 1'b1;
        waitCyc(160); rst = 1'b0;
        checkVal("rst_level", 32'(btn_level), 32'h0);
        checkVal("rst_norel", 32'(btn_release), 32'h0);
        waitCyc(170);
        checkVal("rst_repress_early", 32'(btn_press), 32'h0);
        checkVal("rst_rel_count2", 32'(releaseCnt[2]), 32'd0);
        waitCyc(171);
        checkVal("rst_repress", 32'(btn_press), 32'hF);
        checkVal("rst_level_back", 32'(btn_level), 32'hF);

        // Short low glitch on held channel 0.
        waitCyc(179); btn_raw[0] = 1'b0;
        waitCyc(183); btn_raw[0] = 1'b1;
        waitCyc(200);
        checkVal("glitch_norel", 32'(releaseCnt[0]), 32'd1);
        checkVal("glitch_level", 32'(btn_level[0]), 32'h1);

        // Auto-repeat on channel 3 (press at 171).
        waitCyc(203);
`ifdef BUTTON_AUTOREPEAT_EN
        checkVal("rpt3_count", 32'(repeatCnt[3]), 32'd3);
        checkVal("rpt3_last", 32'(lastRepeat[3]), 32'd201);
`else
        checkVal("rpt3_count", 32'(repeatCnt[3]), 32'd0);
        checkVal("rpt_all_zero", 32'(repeatCnt[0] + repeatCnt[1] + repeatCnt[2]), 32'd0);
`endif

        // Release all.
        waitCyc(209); btn_raw = '0;
        waitCyc(219);
        checkVal("relall_early", 32'(btn_release), 32'h0);
        waitCyc(220);
        checkVal("relall", 32'(btn_release), 32'hF);
        checkVal("relall_level", 32'(btn_level), 32'h0);
        waitCyc(224);

        checkVal("tot_press0", 32'(pressCnt[0]), 32'd3);
        checkVal("tot_press1", 32'(pressCnt[1]), 32'd3);
        checkVal("tot_press2", 32'(pressCnt[2]), 32'd2);
        checkVal("tot_rel0", 32'(releaseCnt[0]), 32'd2);
        checkVal("tot_rel1", 32'(releaseCnt[1]), 32'd2);
        checkVal("tot_rel2", 32'(releaseCnt[2]), 32'd1);
        checkVal("tot_rel3", 32'(releaseCnt[3]), 32'd1);
        checkVal("tot_any", 32'(anyCnt), 32'd4);
        checkVal("any_matches_press", 32'(anyBad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
